// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the EX stage.
//
// A request is accepted in IDLE on start. The unit then runs N iterations in
// CALC, one per clock: radix-2 shift-add for multiplies, restoring
// shift-subtract for divides. In FIX it applies sign correction, the special
// cases, and output selection. The latency from start to done is always N+1
// edges, regardless of the operand values.
//
// Ports:
//   clk     system clock, rising edge
//   rst_n   asynchronous active-low reset
//   start   request strobe, sampled only in IDLE
//   flush   synchronous abort; returns to IDLE, result untouched
//   f3      M-extension funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   a       rs1 operand (multiplicand / dividend)
//   b       rs2 operand (multiplier / divisor)
//   busy    high while an operation is in progress (CALC and FIX)
//   done    one-cycle pulse, result valid
//   result  operation result, held until the next done
module muldiv_unit #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         flush,
  input  logic [2:0]   f3,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [N-1:0]  MIN_NEG = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t state, state_nxt;

  // Two's-complement negate when n is set; used for magnitudes and sign fix.
  function automatic logic [N-1:0] fix_sign_w(input logic [N-1:0] v, input logic n);
    logic signed [N-1:0] s;
    s = v;
    return n ? -s : s;
  endfunction

  function automatic logic [2*N-1:0] fix_sign_dw(input logic [2*N-1:0] v, input logic n);
    logic signed [2*N-1:0] s;
    s = v;
    return n ? -s : s;
  endfunction

  // Latched request
  logic [2:0]     op;
  logic           neg_a, neg_b;
  logic           div_zero, div_ovf;
  logic [N-1:0]   a_lat;
  logic [N-1:0]   mag_a, mag_b;
  logic [CW-1:0]  count;

  // Iteration registers
  logic [2*N-1:0] prod;
  logic [N-1:0]   rem;
  logic [N-1:0]   quo;

  // Request decode on the incoming operands
  logic           accept;
  logic           a_signed_in, b_signed_in;
  logic           neg_a_in, neg_b_in;
  logic           div_zero_in, div_ovf_in;
  logic [N-1:0]   mag_a_in, mag_b_in;

  always_comb begin
    accept      = (state == IDLE) && start && !flush;
    a_signed_in = (f3 == 3'b001) || (f3 == 3'b010) || (f3 == 3'b100) || (f3 == 3'b110);
    b_signed_in = (f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b110);
    neg_a_in    = a_signed_in && a[N-1];
    neg_b_in    = b_signed_in && b[N-1];
    mag_a_in    = fix_sign_w(a, neg_a_in);
    mag_b_in    = fix_sign_w(b, neg_b_in);
    div_zero_in = f3[2] && (b == '0);
    // Signed divide of the most negative value by -1 overflows the quotient.
    div_ovf_in  = ((f3 == 3'b100) || (f3 == 3'b110)) && (a == MIN_NEG) && (b == '1);
  end

  // One iteration step of each algorithm; both run every CALC cycle and the
  // op code selects which outcome is used in FIX.
  logic [N:0]     mul_sum;
  logic [N:0]     div_sh;
  logic           div_ge;
  logic [N-1:0]   div_diff;

  always_comb begin
    // Shift-add: add the multiplicand into the upper half when the current
    // multiplier bit (prod[0]) is set, then shift the whole product right.
    mul_sum  = {1'b0, prod[2*N-1:N]} + (prod[0] ? {1'b0, mag_a} : '0);
    // Restoring divide: bring the next dividend bit into the partial
    // remainder and subtract the divisor only if it fits.
    div_sh   = {rem, quo[N-1]};
    div_ge   = div_sh >= {1'b0, mag_b};
    div_diff = div_sh[N-1:0] - mag_b;
  end

  // Sign correction and output selection for FIX
  logic [2*N-1:0] prod_fix;
  logic [N-1:0]   quo_fix, rem_fix;
  logic [N-1:0]   res_fix;

  always_comb begin
    prod_fix = fix_sign_dw(prod, neg_a ^ neg_b);
    quo_fix  = fix_sign_w(quo, neg_a ^ neg_b);
    rem_fix  = fix_sign_w(rem, neg_a);
    res_fix  = '0;
    case (op)
      3'b000:                 res_fix = prod_fix[N-1:0];
      3'b001, 3'b010, 3'b011: res_fix = prod_fix[2*N-1:N];
      3'b100, 3'b101: begin
        if (div_zero)     res_fix = '1;
        else if (div_ovf) res_fix = MIN_NEG;
        else              res_fix = quo_fix;
      end
      default: begin
        if (div_zero)     res_fix = a_lat;
        else if (div_ovf) res_fix = '0;
        else              res_fix = rem_fix;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; flush wins over everything, including start.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nxt = CALC;
        CALC:    if (count == LAST) state_nxt = FIX;
        FIX:     state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    busy = (state != IDLE);
  end

  // Request latch and iteration datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op       <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      div_zero <= 1'b0;
      div_ovf  <= 1'b0;
      a_lat    <= '0;
      mag_a    <= '0;
      mag_b    <= '0;
      count    <= '0;
      prod     <= '0;
      rem      <= '0;
      quo      <= '0;
    end else if (accept) begin
      op       <= f3;
      neg_a    <= neg_a_in;
      neg_b    <= neg_b_in;
      div_zero <= div_zero_in;
      div_ovf  <= div_ovf_in;
      a_lat    <= a;
      mag_a    <= mag_a_in;
      mag_b    <= mag_b_in;
      count    <= '0;
      prod     <= {{N{1'b0}}, mag_b_in};
      rem      <= '0;
      quo      <= mag_a_in;
    end else if (state == CALC && !flush) begin
      count    <= count + 1'b1;
      prod     <= {mul_sum, prod[N-1:1]};
      rem      <= div_ge ? div_diff : div_sh[N-1:0];
      quo      <= {quo[N-2:0], div_ge};
    end
  end

  // Result register and done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= (state == FIX) && !flush;
      if (state == FIX && !flush) result <= res_fix;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed bench for muldiv_unit with hand-computed results.
module tb_muldiv_unit;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [2:0]   f3 = 3'b000;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [N-1:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.N(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .flush  (flush),
    .f3     (f3),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge: drive the request, let edge E0 take it, then
  // scramble the operand inputs since they need not be held.
  task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    f3 = op; a = x; b = y; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = 32'hDEAD_BEEF;
    b = 32'h0BAD_F00D;
    f3 = op ^ 3'b101;
  endtask

  // Count edges after E0 until done is seen; busy must stay high until then.
  task automatic wait_done(input int e0, output logic [31:0] res, output int lat);
    int e;
    int bad;
    e = e0;
    bad = 0;
    while (!done && e < 80) begin
      if (!busy) bad++;
      @(posedge clk);
      e++;
      @(negedge clk);
    end
    lat = e;
    res = result;
    check("busy_during_op", bad, 0);
    check("busy_in_done_cycle", 32'(busy), 0);
  endtask

  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] exp);
    logic [31:0] res;
    int lat;
    issue(op, x, y);
    wait_done(0, res, lat);
    check({tag, "_result"}, res, exp);
    check({tag, "_latency"}, lat, 33);
  endtask

  initial begin
    logic [31:0] res;
    int lat;
    int seen;

    // Reset state
    #1;
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_result", result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Multiply family
    do_op("mul_neg",    3'b000, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFEB);
    do_op("mulh_min",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    do_op("mulhu_max",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    do_op("mulhsu_neg", 3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF);

    // Divide family, issued back-to-back in the done cycle
    do_op("div_neg",    3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
    do_op("rem_neg",    3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
    do_op("divu",       3'b101, 32'd100,       32'd7,         32'd14);
    do_op("remu",       3'b111, 32'd100,       32'd7,         32'd2);

    // Divide by zero and signed overflow
    do_op("div_by0",    3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF);
    do_op("rem_by0",    3'b110, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9);
    do_op("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    do_op("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

    // Start while busy is ignored
    issue(3'b000, 32'hFFFF_FFFD, 32'd7);
    repeat (9) begin
      @(posedge clk);
      @(negedge clk);
    end
    f3 = 3'b101; a = 32'd5; b = 32'd5; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(10, res, lat);
    check("busy_start_result", res, 32'hFFFF_FFEB);
    check("busy_start_latency", lat, 33);

    // Flush mid-CALC: no done, result unchanged
    issue(3'b101, 32'd100, 32'd7);
    repeat (11) begin
      @(posedge clk);
      @(negedge clk);
    end
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 32'(busy), 0);
    check("flush_done", 32'(done), 0);
    check("flush_result", result, 32'hFFFF_FFEB);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (done) seen++;
    end
    check("flush_no_done", seen, 0);
    check("flush_result_held", result, 32'hFFFF_FFEB);

    // Flush beats start in the same cycle
    start = 1'b1; flush = 1'b1; f3 = 3'b000; a = 32'd3; b = 32'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_over_start_busy", 32'(busy), 0);

    // Asynchronous reset mid-CALC
    issue(3'b000, 32'd7, 32'd7);
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy), 0);
    check("async_rst_done", 32'(done), 0);
    check("async_rst_result", result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (done) seen++;
    end
    check("rst_no_done", seen, 0);
    check("rst_result_zero", result, 0);

    // Recovery after reset
    do_op("post_rst_divu", 3'b101, 32'd100, 32'd7, 32'd14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
